// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipelined core: widths, opcodes,
// forwarding-select encodings, ID/EX FSM states and saturating helpers.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int OPC_W  = 4;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_LD  = 4'b1000;
    localparam logic [3:0] OP_ST  = 4'b1001;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] FWD_WB    = 2'b11;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } idex_state_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/idex_stage_if.sv
// ID/EX boundary bundle: ID-stage fields, hazard-unit controls and forwarding
// sources in; registered fields, EX operands and hold signals out.
interface idex_stage_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int OPC_W  = 4
);
    logic              i_stall;
    logic              i_flush;
    logic              i_id_valid;
    logic [OPC_W-1:0]  i_id_opcode;
    logic [ADDR_W-1:0] i_id_rs1_addr;
    logic [ADDR_W-1:0] i_id_rs2_addr;
    logic [ADDR_W-1:0] i_id_rd_addr;
    logic [DATA_W-1:0] i_id_rs1_data;
    logic [DATA_W-1:0] i_id_rs2_data;
    logic [DATA_W-1:0] i_id_imm;
    logic              i_id_reg_write;
    logic              i_id_mem_read;
    logic              i_id_mem_write;
    logic [1:0]        i_muxA_select;
    logic [1:0]        i_muxB_select;
    logic [DATA_W-1:0] i_exmem_result;
    logic [DATA_W-1:0] i_memwb_result;
    logic [DATA_W-1:0] i_wb_result;

    logic [OPC_W-1:0]  o_idex_opcode;
    logic [ADDR_W-1:0] o_idex_rs1_addr;
    logic [ADDR_W-1:0] o_idex_rs2_addr;
    logic [ADDR_W-1:0] o_idex_rd_addr;
    logic              o_ex_valid;
    logic              o_ex_reg_write;
    logic              o_ex_mem_read;
    logic              o_ex_mem_write;
    logic [DATA_W-1:0] o_ex_operand_a;
    logic [DATA_W-1:0] o_ex_operand_b;
    logic [DATA_W-1:0] o_ex_imm;
    logic              o_pc_hold;
    logic              o_ifid_hold;
    logic              o_wdog_err;

    modport slave (
        input  i_stall, i_flush, i_id_valid, i_id_opcode,
               i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr,
               i_id_rs1_data, i_id_rs2_data, i_id_imm,
               i_id_reg_write, i_id_mem_read, i_id_mem_write,
               i_muxA_select, i_muxB_select,
               i_exmem_result, i_memwb_result, i_wb_result,
        output o_idex_opcode, o_idex_rs1_addr, o_idex_rs2_addr, o_idex_rd_addr,
               o_ex_valid, o_ex_reg_write, o_ex_mem_read, o_ex_mem_write,
               o_ex_operand_a, o_ex_operand_b, o_ex_imm,
               o_pc_hold, o_ifid_hold, o_wdog_err
    );

    modport master (
        output i_stall, i_flush, i_id_valid, i_id_opcode,
               i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr,
               i_id_rs1_data, i_id_rs2_data, i_id_imm,
               i_id_reg_write, i_id_mem_read, i_id_mem_write,
               i_muxA_select, i_muxB_select,
               i_exmem_result, i_memwb_result, i_wb_result,
        input  o_idex_opcode, o_idex_rs1_addr, o_idex_rs2_addr, o_idex_rd_addr,
               o_ex_valid, o_ex_reg_write, o_ex_mem_read, o_ex_mem_write,
               o_ex_operand_a, o_ex_operand_b, o_ex_imm,
               o_pc_hold, o_ifid_hold, o_wdog_err
    );
endinterface

// File: rtl/idex_stage_fwd_mux4.sv
// DATA_W-wide 4:1 forwarding mux choosing between the ID/EX register value
// and the three later-stage results.
module fwd_mux4
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [1:0]        i_sel,
    input  logic [DATA_W-1:0] i_reg,
    input  logic [DATA_W-1:0] i_exmem,
    input  logic [DATA_W-1:0] i_memwb,
    input  logic [DATA_W-1:0] i_wb,
    output logic [DATA_W-1:0] o_data
);

    // Forwarding source select.
    always_comb begin
        o_data = i_reg;
        case (i_sel)
            FWD_REG:   o_data = i_reg;
            FWD_EXMEM: o_data = i_exmem;
            FWD_MEMWB: o_data = i_memwb;
            FWD_WB:    o_data = i_wb;
            default:   o_data = i_reg;
        endcase
    end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with forwarding muxes, stall/flush handling and a
// sticky stall watchdog. Optional HAZARD_PERF_EN adds stall/flush counters.
module idex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int OPC_W    = 4,
    parameter int WDOG_MAX = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    idex_stage_if.slave bus
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0] o_stall_cnt,
    output logic [15:0] o_flush_cnt
`endif
);

    localparam logic [3:0] WDOG_LIM = 4'(WDOG_MAX);

    logic              valid_q,     valid_d;
    logic [OPC_W-1:0]  opcode_q,    opcode_d;
    logic [ADDR_W-1:0] rs1_addr_q,  rs1_addr_d;
    logic [ADDR_W-1:0] rs2_addr_q,  rs2_addr_d;
    logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
    logic [DATA_W-1:0] rs1_data_q,  rs1_data_d;
    logic [DATA_W-1:0] rs2_data_q,  rs2_data_d;
    logic [DATA_W-1:0] imm_q,       imm_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q,  mem_read_d;
    logic              mem_write_q, mem_write_d;
    idex_state_t       state_q,     state_d;
    logic [3:0]        cnt_q,       cnt_d;
    logic              wdog_err_q,  wdog_err_d;
    logic              hold_s;

    assign hold_s = bus.i_stall & ~bus.i_flush;

    // Pipeline field update: flush loads a bubble, stall holds, else capture.
    always_comb begin
        valid_d     = valid_q;
        opcode_d    = opcode_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rd_addr_d   = rd_addr_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        if (bus.i_flush) begin
            valid_d     = 1'b0;
            opcode_d    = OPC_W'(OP_NOP);
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else if (!bus.i_stall) begin
            valid_d     = bus.i_id_valid;
            opcode_d    = bus.i_id_opcode;
            rs1_addr_d  = bus.i_id_rs1_addr;
            rs2_addr_d  = bus.i_id_rs2_addr;
            rd_addr_d   = bus.i_id_rd_addr;
            rs1_data_d  = bus.i_id_rs1_data;
            rs2_data_d  = bus.i_id_rs2_data;
            imm_d       = bus.i_id_imm;
            reg_write_d = bus.i_id_reg_write;
            mem_read_d  = bus.i_id_mem_read;
            mem_write_d = bus.i_id_mem_write;
        end else begin
            valid_d     = valid_q;
        end
    end

    // Stall FSM next state and consecutive-stall counter; watchdog is sticky.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (hold_s) begin
                    state_d = ST_STALL;
                    cnt_d   = 4'd1;
                end else begin
                    cnt_d   = 4'd0;
                end
            end
            ST_STALL: begin
                if (!bus.i_stall || bus.i_flush) begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = sat_inc4(cnt_q);
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        endcase
        wdog_err_d = wdog_err_q | (cnt_d >= WDOG_LIM);
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q     <= 1'b0;
            opcode_q    <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_addr_q   <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state_q     <= ST_RUN;
            cnt_q       <= 4'd0;
            wdog_err_q  <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            opcode_q    <= opcode_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rd_addr_q   <= rd_addr_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wdog_err_q  <= wdog_err_d;
        end
    end

    fwd_mux4 #(.DATA_W(DATA_W)) u_mux_a (
        .i_sel   (bus.i_muxA_select),
        .i_reg   (rs1_data_q),
        .i_exmem (bus.i_exmem_result),
        .i_memwb (bus.i_memwb_result),
        .i_wb    (bus.i_wb_result),
        .o_data  (bus.o_ex_operand_a)
    );

    fwd_mux4 #(.DATA_W(DATA_W)) u_mux_b (
        .i_sel   (bus.i_muxB_select),
        .i_reg   (rs2_data_q),
        .i_exmem (bus.i_exmem_result),
        .i_memwb (bus.i_memwb_result),
        .i_wb    (bus.i_wb_result),
        .o_data  (bus.o_ex_operand_b)
    );

    // The ~i_stall gating is the bubble seen by EX/MEM while ID/EX is held.
    assign bus.o_idex_opcode   = opcode_q;
    assign bus.o_idex_rs1_addr = rs1_addr_q;
    assign bus.o_idex_rs2_addr = rs2_addr_q;
    assign bus.o_idex_rd_addr  = rd_addr_q;
    assign bus.o_ex_valid      = valid_q     & ~bus.i_stall;
    assign bus.o_ex_reg_write  = reg_write_q & ~bus.i_stall;
    assign bus.o_ex_mem_read   = mem_read_q  & ~bus.i_stall;
    assign bus.o_ex_mem_write  = mem_write_q & ~bus.i_stall;
    assign bus.o_ex_imm        = imm_q;
    assign bus.o_pc_hold       = hold_s;
    assign bus.o_ifid_hold     = hold_s;
    assign bus.o_wdog_err      = wdog_err_q;

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = hold_s      ? sat_inc16(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = bus.i_flush ? sat_inc16(flush_cnt_q) : flush_cnt_q;
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_idex_stage.sv
// Directed bench for idex_stage: capture, forwarding, stall, flush+stall,
// watchdog and reset-mid-stall (perf counters when HAZARD_PERF_EN is defined).
module tb_idex_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    idex_stage_if bus ();

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    idex_stage #(.WDOG_MAX(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
`ifdef HAZARD_PERF_EN
        ,
        .o_stall_cnt (stall_cnt),
        .o_flush_cnt (flush_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.i_stall = 1'b0;        bus.i_flush = 1'b0;
        bus.i_id_valid = 1'b0;     bus.i_id_opcode = 4'h0;
        bus.i_id_rs1_addr = 2'd0;  bus.i_id_rs2_addr = 2'd0;  bus.i_id_rd_addr = 2'd0;
        bus.i_id_rs1_data = 8'h00; bus.i_id_rs2_data = 8'h00; bus.i_id_imm = 8'h00;
        bus.i_id_reg_write = 1'b0; bus.i_id_mem_read = 1'b0;  bus.i_id_mem_write = 1'b0;
        bus.i_muxA_select = 2'b00; bus.i_muxB_select = 2'b00;
        bus.i_exmem_result = 8'h00; bus.i_memwb_result = 8'h00; bus.i_wb_result = 8'h00;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_opcode",   16'(bus.o_idex_opcode), 16'h0);
        check("rst_valid",    16'(bus.o_ex_valid),    16'h0);
        check("rst_wdog",     16'(bus.o_wdog_err),    16'h0);
        check("rst_pc_hold",  16'(bus.o_pc_hold),     16'h0);
        check("rst_op_a",     16'(bus.o_ex_operand_a), 16'h0);

        // Capture
        bus.i_id_valid = 1'b1;     bus.i_id_opcode = 4'b0001;
        bus.i_id_rs1_addr = 2'd2;  bus.i_id_rs2_addr = 2'd3; bus.i_id_rd_addr = 2'd1;
        bus.i_id_rs1_data = 8'h11; bus.i_id_rs2_data = 8'h22; bus.i_id_imm = 8'h05;
        bus.i_id_reg_write = 1'b1;
        tick();
        check("cap_opcode",   16'(bus.o_idex_opcode),   16'h1);
        check("cap_rs1_addr", 16'(bus.o_idex_rs1_addr), 16'h2);
        check("cap_rs2_addr", 16'(bus.o_idex_rs2_addr), 16'h3);
        check("cap_rd_addr",  16'(bus.o_idex_rd_addr),  16'h1);
        check("cap_op_a",     16'(bus.o_ex_operand_a),  16'h11);
        check("cap_op_b",     16'(bus.o_ex_operand_b),  16'h22);
        check("cap_imm",      16'(bus.o_ex_imm),        16'h05);
        check("cap_valid",    16'(bus.o_ex_valid),      16'h1);
        check("cap_regwr",    16'(bus.o_ex_reg_write),  16'h1);

        // Forwarding, same cycle as each select
        bus.i_exmem_result = 8'hA5; bus.i_memwb_result = 8'h5A; bus.i_wb_result = 8'h3C;
        bus.i_muxA_select = 2'b01; #1;
        check("fwd_a_exmem", 16'(bus.o_ex_operand_a), 16'hA5);
        bus.i_muxA_select = 2'b10; #1;
        check("fwd_a_memwb", 16'(bus.o_ex_operand_a), 16'h5A);
        bus.i_muxA_select = 2'b11; #1;
        check("fwd_a_wb",    16'(bus.o_ex_operand_a), 16'h3C);
        bus.i_muxB_select = 2'b01; #1;
        check("fwd_b_exmem", 16'(bus.o_ex_operand_b), 16'hA5);
        check("fwd_b_a_wb",  16'(bus.o_ex_operand_a), 16'h3C);
        bus.i_muxA_select = 2'b00; bus.i_muxB_select = 2'b00;

        // Load-use stall for one cycle
        bus.i_id_opcode = 4'b0011; bus.i_id_rs1_addr = 2'd1; bus.i_id_rs2_addr = 2'd0;
        bus.i_id_rd_addr = 2'd2;   bus.i_id_rs1_data = 8'h99; bus.i_id_rs2_data = 8'h88;
        bus.i_stall = 1'b1; #1;
        check("stl_pc_hold",   16'(bus.o_pc_hold),      16'h1);
        check("stl_ifid_hold", 16'(bus.o_ifid_hold),    16'h1);
        check("stl_ex_valid",  16'(bus.o_ex_valid),     16'h0);
        check("stl_ex_regwr",  16'(bus.o_ex_reg_write), 16'h0);
        tick();
        bus.i_stall = 1'b0; #1;
        check("stl_held_op",   16'(bus.o_idex_opcode),   16'h1);
        check("stl_held_rs1",  16'(bus.o_idex_rs1_addr), 16'h2);
        check("stl_held_a",    16'(bus.o_ex_operand_a),  16'h11);
        bus.i_memwb_result = 8'h77; bus.i_muxA_select = 2'b10; #1;
        check("stl_fwd_memwb", 16'(bus.o_ex_operand_a),  16'h77);
        check("stl_valid_back",16'(bus.o_ex_valid),      16'h1);
        bus.i_muxA_select = 2'b00;
        tick();
        check("rel_opcode", 16'(bus.o_idex_opcode),  16'h3);
        check("rel_op_a",   16'(bus.o_ex_operand_a), 16'h99);
        check("rel_op_b",   16'(bus.o_ex_operand_b), 16'h88);

        // Flush together with stall while already stalled
        bus.i_stall = 1'b1;
        tick();
        bus.i_flush = 1'b1; #1;
        check("fls_pc_hold",   16'(bus.o_pc_hold),   16'h0);
        check("fls_ifid_hold", 16'(bus.o_ifid_hold), 16'h0);
        tick();
        bus.i_flush = 1'b0; bus.i_stall = 1'b0; #1;
        check("fls_valid",  16'(bus.o_ex_valid),     16'h0);
        check("fls_regwr",  16'(bus.o_ex_reg_write), 16'h0);
        check("fls_opcode", 16'(bus.o_idex_opcode),  16'h0);
        check("fls_state",  16'(dut.state_q),        16'(ST_RUN));

        // Watchdog on a bubble entry held for four cycles
        bus.i_stall = 1'b1; #1;
        check("wd_bubble_hold", 16'(bus.o_pc_hold), 16'h1);
        tick(); tick(); tick();
        check("wd_before", 16'(bus.o_wdog_err), 16'h0);
        tick();
        check("wd_set",    16'(bus.o_wdog_err), 16'h1);
        bus.i_stall = 1'b0;
        tick();
        check("wd_sticky", 16'(bus.o_wdog_err), 16'h1);
`ifdef HAZARD_PERF_EN
        check("perf_stall6", stall_cnt, 16'd6);
        check("perf_flush1", flush_cnt, 16'd1);
`endif

        // Reset, capture, three stalls, then reset mid-stall
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        check("rst2_wdog", 16'(bus.o_wdog_err), 16'h0);
        tick();
        check("rst2_cap_op", 16'(bus.o_idex_opcode), 16'h3);
        bus.i_stall = 1'b1;
        tick(); tick(); tick();
        check("rms_wdog_3", 16'(bus.o_wdog_err),    16'h0);
        check("rms_held",   16'(bus.o_idex_opcode), 16'h3);
`ifdef HAZARD_PERF_EN
        check("perf_stall3", stall_cnt, 16'd3);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.i_stall = 1'b0; #1;
        check("rms_state",   16'(dut.state_q),       16'(ST_RUN));
        check("rms_opcode",  16'(bus.o_idex_opcode), 16'h0);
        check("rms_valid",   16'(bus.o_ex_valid),    16'h0);
        check("rms_pc_hold", 16'(bus.o_pc_hold),     16'h0);
        check("rms_wdog",    16'(bus.o_wdog_err),    16'h0);
`ifdef HAZARD_PERF_EN
        check("perf_stall0", stall_cnt, 16'd0);
        check("perf_flush0", flush_cnt, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
